fp_stream_accumulator: RTL and testbench
========================================

Name: fp_stream_accumulator

Overview:
- Sequencer that sums a stream of IEEE-754 single-precision operands using the team's existing combinational floating-point adder.
- The adder is instantiated outside this block. This block drives the adder's two operand inputs from registers and samples its sum output.
- Placed directly upstream of the adder, which it feeds, and downstream of the operand source. The result is returned to the requester through a valid/ready handshake.
- The adder always assumes a hidden leading 1, so this block handles zero and denormal operands itself.

Parameters:
- COUNT_W, 8, width of the operand-count field
- ADD_LAT, 1, cycles from operand register update to add_sum sampling; minimum 1; greater than 1 covers a pipelined adder
- W, 32, floating-point word width (sign, 8-bit exponent, 23-bit mantissa)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin an accumulation; sampled only in IDLE
- count  in  COUNT_W  number of operands to consume; latched on start
- in_data  in  W  operand
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid and in_ready are both high
- add_a  out  W  adder operand A (accumulator)
- add_b  out  W  adder operand B (incoming operand)
- add_sum  in  W  adder result
- out_data  out  W  final sum
- out_valid  out  1  final sum valid
- out_ready  in  1  final sum consumed
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: in_ready=0, add_a=0, add_b=0, out_data=0, out_valid=0, busy=0. Internal registers reset to state=IDLE, acc=0, acc_zero=1, remaining=0, lat_cnt=0.
- Reset asserted mid-operation aborts immediately. Any partial sum is discarded and no out_valid is produced.
- A zero operand means exponent field == 0; the mantissa is ignored, so denormals are flushed to zero.
- IDLE:
  - On start, latch remaining=count, set acc_zero=1 and acc=0.
  - count==0 goes to DONE; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1 in this state only.
  - On an input handshake, one of three cases applies:
    - Zero operand: skip it (remaining-1).
    - acc_zero==1: load acc=in_data, clear acc_zero, remaining-1. No adder use.
    - Otherwise: register add_a=acc and add_b=in_data, set lat_cnt=ADD_LAT, go to ADD.
  - After a skip or load, if remaining reaches 0, go to DONE; otherwise stay in ACCUM.
- ADD:
  - in_ready=0. add_a and add_b are held stable.
  - lat_cnt decrements each cycle. When it reaches 0, capture acc=add_sum and decrement remaining.
  - If the captured exponent==0 (exact cancellation), set acc_zero=1.
  - add_a and add_b return to 0 on leaving ADD.
  - Next state is DONE if remaining==0, else ACCUM.
  - Timing: with ADD_LAT=1, an operand accepted in cycle N is captured into acc in cycle N+2.
- Special values: exponent field 0xFF is passed through the adder unchanged. Its result is taken as-is, with no local NaN/Inf handling.
- DONE:
  - out_valid=1. out_data = 0 if acc_zero, else acc.
  - out_data is held stable until an out_ready handshake, which returns the block to IDLE with out_valid=0 the following cycle.
- start is ignored outside IDLE. start and the DONE handshake in the same cycle do not chain; start must be reasserted in IDLE.
- remaining is compared before decrement, so there is no wrap-around. With count=2^COUNT_W-1, all operands are consumed.
- in_valid while not in ACCUM is ignored, with no data loss on the source side because in_ready is low.

Test Plan:
- Basic sum: start with count=3, stream 0x3F800000, 0x40000000, 0x40400000 (1.0, 2.0, 3.0), bench-supplied adder model -> out_data=0x40C00000 (6.0), ADD entered twice, out_valid within 9 cycles of the first handshake.
- Zero skip: count=2, operands 0x00000000 then 0x40000000 -> out_data=0x40000000. add_a and add_b stay 0 throughout, and ADD is never entered.
- Cancellation: count=3, operands 0x40000000, 0xC0000000, 0x3F800000 -> after the second operand acc_zero=1, and the third is a direct load, giving out_data=0x3F800000.
- Empty job: start with count=0 -> out_valid=1 with out_data=0x00000000 on the cycle after start, and in_ready never asserted.
- Backpressure: hold out_ready low for 5 cycles in DONE -> out_data and out_valid stable, in_ready=0, and start pulses are ignored; release -> IDLE next cycle and busy=0.
- Reset mid-ADD with ADD_LAT=3: assert rst_n=0 during the second ADD cycle -> all outputs 0 immediately; after release, a new job count=1 with 0x40400000 -> 0x40400000.

Source files
------------

// File: rtl/fp_stream_accumulator_if.sv
// Operand stream and result handshake bundle for fp_stream_accumulator.
// The master side is the requester/operand source; the slave side is the accumulator.
interface fp_stream_accumulator_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/fp_stream_accumulator.sv
// Sums a stream of single-precision operands through an external combinational
// (or pipelined) adder. Zero and denormal operands never reach the adder, because
// the adder always assumes a hidden leading 1; they are skipped or loaded directly.
module fp_stream_accumulator #(
  parameter int COUNT_W = 8,
  parameter int ADD_LAT = 1,
  parameter int W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_W-1:0]     count,
  fp_stream_accumulator_if.slave bus,
  output logic [W-1:0]           add_a,
  output logic [W-1:0]           add_b,
  input  logic [W-1:0]           add_sum,
  output logic                   busy
);

  localparam int EXP_MSB = W - 2;
  localparam int EXP_LSB = W - 9;
  localparam int LAT_W   = $clog2(ADD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ADD_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ADD,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [W-1:0]       r_acc;
  logic               r_acc_zero;
  logic [COUNT_W-1:0] r_remaining;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [W-1:0]       r_add_a;
  logic [W-1:0]       r_add_b;

  logic w_in_zero;
  logic w_last;
  logic w_lat_done;
  logic w_sum_zero;

  // Exponent field of zero marks a zero/denormal; the mantissa is deliberately ignored.
  assign w_in_zero  = (bus.in_data[EXP_MSB:EXP_LSB] == '0);
  assign w_sum_zero = (add_sum[EXP_MSB:EXP_LSB] == '0);
  // remaining is tested before it is decremented, so a full-scale count never wraps.
  assign w_last     = (r_remaining == COUNT_W'(1));
  // The adder result is sampled on the edge where lat_cnt reaches zero.
  assign w_lat_done = (r_lat_cnt == LAT_W'(1));

  assign add_a = r_add_a;
  assign add_b = r_add_b;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of process ordering.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (count == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          if (w_in_zero || r_acc_zero) begin
            w_next_state = w_last ? S_DONE : S_ACCUM;
          end else begin
            w_next_state = S_ADD;
          end
        end
      end
      S_ADD: begin
        if (w_lat_done) begin
          w_next_state = w_last ? S_DONE : S_ACCUM;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from the current state only.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    busy          = (r_state != S_IDLE);
    unique case (r_state)
      S_ACCUM: bus.in_ready = 1'b1;
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_acc_zero ? '0 : r_acc;
      end
      default: ;
    endcase
  end

  // Accumulator, operand count, adder operands and adder latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_acc_zero  <= 1'b1;
      r_remaining <= '0;
      r_lat_cnt   <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remaining <= count;
            r_acc       <= '0;
            r_acc_zero  <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            if (w_in_zero) begin
              r_remaining <= r_remaining - 1'b1;
            end else if (r_acc_zero) begin
              // First non-zero operand is loaded directly; there is nothing to add it to.
              r_acc       <= bus.in_data;
              r_acc_zero  <= 1'b0;
              r_remaining <= r_remaining - 1'b1;
            end else begin
              r_add_a   <= r_acc;
              r_add_b   <= bus.in_data;
              r_lat_cnt <= LAT_INIT;
            end
          end
        end
        S_ADD: begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
          if (w_lat_done) begin
            r_acc       <= add_sum;
            // Exact cancellation yields a zero exponent; the next operand must be loaded, not added.
            r_acc_zero  <= w_sum_zero;
            r_remaining <= r_remaining - 1'b1;
            r_add_a     <= '0;
            r_add_b     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Scoreboard bench for fp_stream_accumulator. Expected sums are pushed when a job
// is issued; per-instance monitors pop and compare on each result handshake.
// u_dut1 uses ADD_LAT=1, u_dut3 uses ADD_LAT=3 for the mid-ADD reset scenario.
module tb_fp_stream_accumulator;

  localparam int W  = 32;
  localparam int CW = 8;

  localparam logic [31:0] F0   = 32'h0000_0000;
  localparam logic [31:0] F1   = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2   = 32'h4000_0000;  // 2.0
  localparam logic [31:0] FM2  = 32'hC000_0000;  // -2.0
  localparam logic [31:0] F3   = 32'h4040_0000;  // 3.0
  localparam logic [31:0] F6   = 32'h40C0_0000;  // 6.0
  localparam logic [31:0] F255 = 32'h437F_0000;  // 255.0

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // Reference adder: normal operands only, truncating, as the real adder would see them.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [49:0] ma, mb, m;
    logic [7:0]  e;
    int          d;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] < b[30:0]) begin x = b; y = a; end
    else begin x = a; y = b; end
    ma = {2'b01, x[22:0], 25'd0};
    mb = {2'b01, y[22:0], 25'd0};
    d  = int'(x[30:23]) - int'(y[30:23]);
    mb = (d > 49) ? 50'd0 : (mb >> d);
    e  = x[30:23];
    m  = (x[31] == y[31]) ? (ma + mb) : (ma - mb);
    if (m == 50'd0) return 32'h0;
    if (m[49]) begin m = m >> 1; e = e + 8'd1; end
    while (!m[48]) begin m = m << 1; e = e - 8'd1; end
    return {x[31], e, m[47:25]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instance with ADD_LAT=1 ----------------
  fp_stream_accumulator_if #(.W(W)) bus1 ();
  logic          start1;
  logic [CW-1:0] count1;
  logic [W-1:0]  add_a1, add_b1, add_sum1;
  logic          busy1;

  fp_stream_accumulator #(.COUNT_W(CW), .ADD_LAT(1), .W(W)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start1),
    .count   (count1),
    .bus     (bus1),
    .add_a   (add_a1),
    .add_b   (add_b1),
    .add_sum (add_sum1),
    .busy    (busy1)
  );
  always_comb add_sum1 = fp_add(add_a1, add_b1);

  // ---------------- instance with ADD_LAT=3 ----------------
  fp_stream_accumulator_if #(.W(W)) bus3 ();
  logic          start3;
  logic [CW-1:0] count3;
  logic [W-1:0]  add_a3, add_b3, add_sum3;
  logic          busy3;

  fp_stream_accumulator #(.COUNT_W(CW), .ADD_LAT(3), .W(W)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start3),
    .count   (count3),
    .bus     (bus3),
    .add_a   (add_a3),
    .add_b   (add_b3),
    .add_sum (add_sum3),
    .busy    (busy3)
  );
  always_comb add_sum3 = fp_add(add_a3, add_b3);

  // ---------------- scoreboards and monitors ----------------
  logic [31:0] q1[$];
  logic [31:0] q3[$];
  logic [31:0] exp1, exp3;

  always @(negedge clk) begin
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected_result: got %h, expected no result", bus1.out_data);
      end else begin
        exp1 = q1.pop_front();
        check("dut1_out_data", bus1.out_data, exp1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus3.out_valid && bus3.out_ready) begin
      if (q3.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut3_unexpected_result: got %h, expected no result", bus3.out_data);
      end else begin
        exp3 = q3.pop_front();
        check("dut3_out_data", bus3.out_data, exp3);
      end
    end
  end

  // Observers on dut1: ADD entries (add_a leaves zero), any adder use, any in_ready.
  logic prev_add1     = 1'b0;
  int   add_entries1  = 0;
  bit   add_used1     = 1'b0;
  bit   in_ready_seen1 = 1'b0;
  always @(negedge clk) begin
    if ((add_a1 != '0) && !prev_add1) add_entries1++;
    prev_add1 = (add_a1 != '0);
    if ((add_a1 != '0) || (add_b1 != '0)) add_used1 = 1'b1;
    if (bus1.in_ready) in_ready_seen1 = 1'b1;
  end

  // ---------------- stimulus tasks ----------------
  task automatic start_job1(input logic [CW-1:0] c);
    @(posedge clk); #1;
    start1 = 1'b1;
    count1 = c;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic start_job3(input logic [CW-1:0] c);
    @(posedge clk); #1;
    start3 = 1'b1;
    count3 = c;
    @(posedge clk); #1;
    start3 = 1'b0;
  endtask

  // Offer one operand and hold it until accepted; hs_cyc is the cycle count after the handshake edge.
  task automatic send1(input logic [31:0] d, output int hs_cyc);
    bit ok = 1'b0;
    bus1.in_data  = d;
    bus1.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus1.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    hs_cyc = cyc;
    bus1.in_valid = 1'b0;
    if (!ok) check("dut1_in_ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send3(input logic [31:0] d);
    bit ok = 1'b0;
    bus3.in_data  = d;
    bus3.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus3.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    if (!ok) check("dut3_in_ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_out1(output int at_cyc);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus1.out_valid) begin ok = 1'b1; break; end
    end
    at_cyc = cyc;
    check("dut1_out_valid_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out3();
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus3.out_valid) begin ok = 1'b1; break; end
    end
    check("dut3_out_valid_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hs, hs_first, t_out;

    start1 = 1'b0; count1 = '0; bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    start3 = 1'b0; count3 = '0; bus3.in_data = '0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus1.in_ready),  32'd0);
    check("rst_add_a",     add_a1,              F0);
    check("rst_add_b",     add_b1,              F0);
    check("rst_out_data",  bus1.out_data,       F0);
    check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    check("rst_busy",      32'(busy1),          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sum 1+2+3 = 6, two ADD visits, bounded latency.
    add_entries1 = 0;
    q1.push_back(F6);
    start_job1(8'd3);
    send1(F1, hs_first);
    send1(F2, hs);
    send1(F3, hs);
    wait_out1(t_out);
    check("basic_add_entries", 32'(add_entries1), 32'd2);
    check("basic_latency_le_9", 32'((t_out - hs_first) <= 9), 32'd1);

    // Zero operand skipped; second operand loaded directly, adder never used.
    add_entries1 = 0;
    add_used1    = 1'b0;
    q1.push_back(F2);
    start_job1(8'd2);
    send1(F0, hs);
    send1(F2, hs);
    wait_out1(t_out);
    check("zskip_add_used",    32'(add_used1),    32'd0);
    check("zskip_add_entries", 32'(add_entries1), 32'd0);

    // Exact cancellation then direct load: 2 + -2 -> zero, 1 loaded -> 1.
    add_entries1 = 0;
    q1.push_back(F1);
    start_job1(8'd3);
    send1(F2, hs);
    send1(FM2, hs);
    send1(F1, hs);
    wait_out1(t_out);
    check("cancel_add_entries", 32'(add_entries1), 32'd1);

    // Empty job: result on the cycle after start, no operand ever requested.
    in_ready_seen1 = 1'b0;
    q1.push_back(F0);
    start_job1(8'd0);
    @(negedge clk);
    check("empty_out_valid", 32'(bus1.out_valid), 32'd1);
    check("empty_out_data",  bus1.out_data,       F0);
    @(posedge clk); #1;
    check("empty_in_ready_never", 32'(in_ready_seen1), 32'd0);

    // Full-scale count: 255 ones -> 255.0, no wrap of the remaining counter.
    q1.push_back(F255);
    start_job1(8'd255);
    for (int i = 0; i < 255; i++) send1(F1, hs);
    wait_out1(t_out);

    // Backpressure: result held for 5 cycles, start pulses ignored, no chaining on release.
    bus1.out_ready = 1'b0;
    q1.push_back(F3);
    start_job1(8'd1);
    send1(F3, hs);
    wait_out1(t_out);
    for (int i = 0; i < 5; i++) begin
      start1 = 1'b1;
      count1 = 8'd0;
      @(negedge clk);
      check("bp_out_data",  bus1.out_data,       F3);
      check("bp_out_valid", 32'(bus1.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus1.in_ready),  32'd0);
      @(posedge clk); #1;
    end
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    check("bp_release_busy",      32'(busy1),          32'd0);
    check("bp_release_out_valid", 32'(bus1.out_valid), 32'd0);

    // ADD_LAT=3: a normal add job, then reset during the second ADD cycle.
    q3.push_back(F3);
    start_job3(8'd2);
    send3(F1);
    send3(F2);
    wait_out3();

    start_job3(8'd2);
    send3(F1);
    send3(F2);             // returns one step into the first ADD cycle
    @(posedge clk); #1;    // second ADD cycle
    check("mid_add_a", add_a3, F1);
    check("mid_add_b", add_b3, F2);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  32'(bus3.in_ready),  32'd0);
    check("abort_add_a",     add_a3,              F0);
    check("abort_add_b",     add_b3,              F0);
    check("abort_out_data",  bus3.out_data,       F0);
    check("abort_out_valid", 32'(bus3.out_valid), 32'd0);
    check("abort_busy",      32'(busy3),          32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    q3.push_back(F3);
    start_job3(8'd1);
    send3(F3);
    wait_out3();

    repeat (5) @(posedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
